display_scheduler: RTL
======================

// Module: display_scheduler
// PURPOSE
//   Sequences a 128-bit AES block, one byte at a time, onto the 2-digit hex
//   seven-segment display driver. byte_out feeds the display's 8-bit data input.
//   Accepts one block per valid/ready handshake, then holds each byte for HOLD
//   cycles, MSB byte first. Supports pause and abort.
//   Pulses done after the last byte has been shown for its full dwell time.
// PARAMETERS
//   NBYTES  16        bytes per block; blk_data width = 8*NBYTES
//   HOLD    50000000  dwell cycles per byte; must be >= 1
//   CW      26        dwell counter width; must satisfy 2**CW >= HOLD
// PORTS
//   clk        in   1         system clock; the block uses this clock only
//   rst        in   1         reset, synchronous, active-low
//   blk_valid  in   1         source has a block on blk_data
//   blk_data   in   8*NBYTES  block; byte 0 = blk_data[8*NBYTES-1 -: 8]
//   blk_ready  out  1         block can accept a new block (registered)
//   pause      in   1         freezes the dwell counter while high
//   abort      in   1         drops the current block and returns to IDLE
//   byte_out   out  8         byte currently shown (registered)
//   byte_idx   out  4         index of byte_out within the block (registered)
//   busy       out  1         high while in SHOW (registered)
//   done       out  1         1-cycle pulse at block completion (registered)
// BEHAVIOUR
//   Reset (rst==0 at posedge): state=IDLE, blk_ready=0, busy=0, done=0,
//     byte_out=8'h00, byte_idx=0, cnt=0, block register=0.
//   blk_ready rises at the first posedge with rst==1. It is never high in reset.
//   States: IDLE and SHOW. All outputs update on the same edge as the state.
//   IDLE
//     blk_ready=1 from the edge after reset. pause is ignored.
//     byte_out and byte_idx keep their last values.
//     Accept condition: blk_valid && blk_ready at posedge. On that edge:
//       latch blk_data; state=SHOW; blk_ready=0; busy=1; cnt=0; byte_idx=0;
//       byte_out=byte 0. The new byte appears with zero extra latency.
//   SHOW
//     Each edge with pause==0 increments cnt. With pause==1, cnt holds.
//     Edge with cnt==HOLD-1, pause==0 and byte_idx<NBYTES-1:
//       cnt=0; byte_idx++; byte_out=next byte.
//     Edge with cnt==HOLD-1, pause==0 and byte_idx==NBYTES-1:
//       state=IDLE; busy=0; blk_ready=1; done=1 for exactly that one cycle.
//       byte_out keeps the last byte.
//     Result: each byte is shown for exactly HOLD unpaused cycles.
//       Unpaused block time is NBYTES*HOLD cycles from acceptance to done.
//   abort (synchronous, any state):
//     state=IDLE; busy=0; cnt=0; done stays 0; blk_ready=1 on the next edge.
//     byte_out and byte_idx keep their values.
//   Priority: rst > abort > completion/advance > pause.
//   Boundary cases
//     - blk_valid is ignored while blk_ready==0, including in the done cycle.
//     - A new block can be accepted on the first edge after done.
//     - HOLD==1: the byte advances on every unpaused edge.
//     - pause held on the last count: completion is delayed until pause drops.
//     - rst asserted mid-block: full reset values; the block is lost; no done.
//     - cnt must never exceed HOLD-1, so there is no wrap-around beyond HOLD.
// TESTING (bench uses HOLD=4, NBYTES=16)
//   1 Reset, release, blk_valid=1 with 0x00112233445566778899AABBCCDDEEFF.
//     -> ready=1 one cycle after release; byte_out=00 at the accept edge.
//     -> bytes 00,11,..,FF each held for 4 cycles.
//     -> done pulses 1 cycle, 64 cycles after accept; busy falls on the same edge.
//   2 pause high for 10 cycles during byte_idx=5.
//     -> byte_out stays 0x55 for 14 cycles; done is 10 cycles later than in test 1.
//   3 abort at byte_idx=7.
//     -> IDLE, busy=0, no done, byte_out stays 0x77.
//     -> the next block is accepted and starts at byte 0.
//   4 blk_valid held high continuously.
//     -> not accepted in the done cycle; re-accepted 1 cycle after done.
//     -> the second block starts from its own byte 0.
//   5 rst low for 1 cycle at byte_idx=9.
//     -> all outputs return to reset values; no done pulse.
//   6 HOLD=1 build: feed one block.
//     -> 16 consecutive bytes, one per cycle, then done.

Source files
------------

// File: rtl/display_scheduler.sv
// display_scheduler
// Walks a latched multi-byte block onto an 8-bit display input, most significant
// byte first, dwelling HOLD unpaused cycles on each byte. Supports pause and
// abort, and pulses done once the final byte has completed its dwell.
module display_scheduler #(
    parameter int NBYTES = 16,
    parameter int HOLD   = 50000000,
    parameter int CW     = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  blk_valid,
    input  logic [8*NBYTES-1:0]   blk_data,
    output logic                  blk_ready,
    input  logic                  pause,
    input  logic                  abort,
    output logic [7:0]            byte_out,
    output logic [3:0]            byte_idx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NBYTES - 1);

    state_t                state_reg,    state_next;
    logic [CW-1:0]         cnt_reg,      cnt_next;
    logic [8*NBYTES-1:0]   blk_reg,      blk_next;
    logic [7:0]            byte_out_reg, byte_out_next;
    logic [3:0]            byte_idx_reg, byte_idx_next;
    logic                  ready_reg,    ready_next;
    logic                  busy_reg,     busy_next;
    logic                  done_reg,     done_next;

    logic [7:0]            byte_arr [NBYTES];
    logic [3:0]            idx_inc;

    // Byte view of the latched block: entry 0 is the most significant byte.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign byte_arr[gi] = blk_reg[8*(NBYTES-gi)-1 -: 8];
        end
    endgenerate

    assign idx_inc = byte_idx_reg + 4'd1;

    // State and output registers; reset clears everything including the block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            blk_reg      <= '0;
            byte_out_reg <= 8'h00;
            byte_idx_reg <= 4'd0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            blk_reg      <= blk_next;
            byte_out_reg <= byte_out_next;
            byte_idx_reg <= byte_idx_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Next-state logic: abort overrides acceptance, advance and completion.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        blk_next      = blk_reg;
        byte_out_next = byte_out_reg;
        byte_idx_next = byte_idx_reg;
        ready_next    = ready_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;

        if (abort) begin
            // Drop the block; displayed byte and index are left as they were.
            state_next = IDLE;
            busy_next  = 1'b0;
            cnt_next   = '0;
            ready_next = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    ready_next = 1'b1;
                    // Acceptance uses the registered ready, so the first edge
                    // out of reset and the completion edge cannot accept.
                    if (blk_valid && ready_reg) begin
                        state_next    = SHOW;
                        ready_next    = 1'b0;
                        busy_next     = 1'b1;
                        cnt_next      = '0;
                        byte_idx_next = 4'd0;
                        blk_next      = blk_data;
                        byte_out_next = blk_data[8*NBYTES-1 -: 8];
                    end
                end
                SHOW: begin
                    if (!pause) begin
                        if (cnt_reg == CNT_LAST) begin
                            cnt_next = '0;
                            if (byte_idx_reg == IDX_LAST) begin
                                // Last byte finished its dwell; keep it displayed.
                                state_next = IDLE;
                                busy_next  = 1'b0;
                                ready_next = 1'b1;
                                done_next  = 1'b1;
                            end else begin
                                byte_idx_next = idx_inc;
                                byte_out_next = byte_arr[idx_inc];
                            end
                        end else begin
                            cnt_next = cnt_reg + CW'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign blk_ready = ready_reg;
    assign byte_out  = byte_out_reg;
    assign byte_idx  = byte_idx_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
